// File: rtl/e_mdu_pkg.sv
// Shared MDU operation codes, FSM state encoding and arithmetic helpers for e_mdu.
// The MADD-class codes are always defined here; e_mdu only decodes them under MDU_MADD_EN.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] ext64(input logic [31:0] v, input logic sgn);
    return sgn ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO; fixed-latency MULT/DIV with delayed commit.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU (accumulate into {HI,LO}).
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HILO_out
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  mdu_state_e  state_q;
  logic        busy_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] temp_hi_q, temp_lo_q;
  logic        commit_en_q;

  logic        is_mul_s, is_div_s, is_sgn_s, is_acc_s, is_sub_s, is_start_op_s;
  logic [CW-1:0] cnt_load_s;
  logic [31:0] temp_hi_d, temp_lo_d;
  logic        commit_en_d;

  logic [63:0] product_s, acc_s, mul_res_s;
  logic        a_neg_s, b_neg_s, div_zero_s;
  logic [31:0] a_mag_s, b_mag_s, b_safe_s, q_mag_s, r_mag_s, quo_s, rem_s;

  // Decode the op into operation class, signedness and latency.
  always_comb begin
    is_mul_s   = 1'b0;
    is_div_s   = 1'b0;
    is_sgn_s   = 1'b0;
    is_acc_s   = 1'b0;
    is_sub_s   = 1'b0;
    case (mdu_op)
      MDU_MULT:  begin is_mul_s = 1'b1; is_sgn_s = 1'b1; end
      MDU_MULTU: begin is_mul_s = 1'b1; end
      MDU_DIV:   begin is_div_s = 1'b1; is_sgn_s = 1'b1; end
      MDU_DIVU:  begin is_div_s = 1'b1; end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin is_mul_s = 1'b1; is_sgn_s = 1'b1; is_acc_s = 1'b1; end
      MDU_MADDU: begin is_mul_s = 1'b1; is_acc_s = 1'b1; end
      MDU_MSUB:  begin is_mul_s = 1'b1; is_sgn_s = 1'b1; is_acc_s = 1'b1; is_sub_s = 1'b1; end
      MDU_MSUBU: begin is_mul_s = 1'b1; is_acc_s = 1'b1; is_sub_s = 1'b1; end
`endif
      default: begin
        is_mul_s = 1'b0;
        is_div_s = 1'b0;
      end
    endcase
    is_start_op_s = is_mul_s | is_div_s;
    if (is_div_s) begin
      cnt_load_s = CW'(DIV_CYCLES);
    end else begin
      cnt_load_s = CW'(MULT_CYCLES);
    end
  end

  // Multiply path: extended operands give the exact product modulo 2^64.
  always_comb begin
    product_s = ext64(A, is_sgn_s) * ext64(B, is_sgn_s);
    acc_s     = {hi_q, lo_q};
    if (!is_acc_s) begin
      mul_res_s = product_s;
    end else if (is_sub_s) begin
      mul_res_s = acc_s - product_s;
    end else begin
      mul_res_s = acc_s + product_s;
    end
  end

  // Divide path on magnitudes; signs restored so the quotient truncates toward
  // zero and the remainder follows the dividend. 0x80000000/-1 falls out naturally.
  always_comb begin
    a_neg_s    = is_sgn_s & A[31];
    b_neg_s    = is_sgn_s & B[31];
    a_mag_s    = neg32(A, a_neg_s);
    b_mag_s    = neg32(B, b_neg_s);
    div_zero_s = (B == 32'd0);
    if (div_zero_s) begin
      b_safe_s = 32'd1;
    end else begin
      b_safe_s = b_mag_s;
    end
    q_mag_s = a_mag_s / b_safe_s;
    r_mag_s = a_mag_s % b_safe_s;
    quo_s   = neg32(q_mag_s, a_neg_s ^ b_neg_s);
    rem_s   = neg32(r_mag_s, a_neg_s);
  end

  // Select the value captured into the temp registers at the start edge.
  always_comb begin
    if (is_div_s) begin
      temp_hi_d   = rem_s;
      temp_lo_d   = quo_s;
      commit_en_d = ~div_zero_s;
    end else begin
      temp_hi_d   = mul_res_s[63:32];
      temp_lo_d   = mul_res_s[31:0];
      commit_en_d = 1'b1;
    end
  end

  assign start = valid & is_start_op_s & ~busy_q;
  assign busy  = busy_q;

  // Read port sees only committed HI/LO.
  always_comb begin
    case (mdu_op)
      MDU_MFHI: HILO_out = hi_q;
      MDU_MFLO: HILO_out = lo_q;
      default:  HILO_out = 32'd0;
    endcase
  end

  // Control FSM, latency counter and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= MDU_IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      temp_hi_q   <= 32'd0;
      temp_lo_q   <= 32'd0;
      commit_en_q <= 1'b0;
    end else begin
      case (state_q)
        MDU_IDLE: begin
          if (start) begin
            state_q     <= MDU_BUSY;
            busy_q      <= 1'b1;
            cnt_q       <= cnt_load_s;
            temp_hi_q   <= temp_hi_d;
            temp_lo_q   <= temp_lo_d;
            commit_en_q <= commit_en_d;
          end else if (valid && !busy_q && (mdu_op == MDU_MTHI)) begin
            hi_q <= A;
          end else if (valid && !busy_q && (mdu_op == MDU_MTLO)) begin
            lo_q <= A;
          end else begin
            busy_q <= 1'b0;
          end
        end
        MDU_BUSY: begin
          if (cnt_q == CW'(1)) begin
            state_q <= MDU_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (commit_en_q) begin
              hi_q <= temp_hi_q;
              lo_q <= temp_lo_q;
            end else begin
              hi_q <= hi_q;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= MDU_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed scoreboard bench for e_mdu (default parameters, MDU_MADD_EN undefined).
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] HILO_out;

  e_mdu dut (
    .clk(clk), .reset(reset), .valid(valid), .mdu_op(mdu_op),
    .A(A), .B(B), .start(start), .busy(busy), .HILO_out(HILO_out)
  );

  always #5 clk = ~clk;

  typedef enum int {K_HILO, K_BUSY, K_START} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Monitor: compares every expectation posted for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_HILO:  act = HILO_out;
        K_BUSY:  act = {31'd0, busy};
        default: act = {31'd0, start};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic push(input kind_e k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k; e.val = v; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    valid = v; mdu_op = op; A = a; B = b;
  endtask

  task automatic rd(input logic [31:0] hi, input logic [31:0] lo, input string tag);
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    push(K_HILO, hi, {tag, " HI"});
    cyc();
    drive(1'b1, MDU_MFLO, 32'd0, 32'd0);
    push(K_HILO, lo, {tag, " LO"});
    cyc();
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
  endtask

  // Issue one op, check start, exact busy length and the committed result.
  // With snoop set, reads, a blocked start and an MTLO are attempted while busy.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input bit snoop, input logic [31:0] old_hi,
                        input logic [31:0] old_lo, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input string tag);
    drive(1'b1, op, a, b);
    push(K_START, 32'd1, {tag, " start"});
    push(K_BUSY, 32'd0, {tag, " busy pre"});
    cyc();
    for (int i = 1; i <= n; i++) begin
      drive(1'b0, MDU_NONE, 32'd0, 32'd0);
      if (snoop) begin
        case (i)
          1: begin drive(1'b1, MDU_MFHI, 32'd0, 32'd0); push(K_HILO, old_hi, {tag, " old HI"}); end
          2: begin drive(1'b1, MDU_MFLO, 32'd0, 32'd0); push(K_HILO, old_lo, {tag, " old LO"}); end
          3: begin drive(1'b1, MDU_MULT, a, b); push(K_START, 32'd0, {tag, " start gated"}); end
          4: drive(1'b1, MDU_MTLO, 32'h5678, 32'd0);
          default: drive(1'b0, MDU_NONE, 32'd0, 32'd0);
        endcase
      end
      push(K_BUSY, 32'd1, $sformatf("%s busy c%0d", tag, i));
      cyc();
    end
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    push(K_BUSY, 32'd0, {tag, " busy fall"});
    push(K_HILO, exp_hi, {tag, " HI"});
    cyc();
    drive(1'b1, MDU_MFLO, 32'd0, 32'd0);
    push(K_HILO, exp_lo, {tag, " LO"});
    cyc();
    drive(1'b0, MDU_NONE, 32'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    cyc();
    drive(1'b0, MDU_MFHI, 32'd0, 32'd0);
    push(K_HILO, 32'd0, "reset HI");
    push(K_BUSY, 32'd0, "reset busy");
    cyc();
    reset = 1'b1;
    rd(32'd0, 32'd0, "post-reset");

    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 32'd0, 32'd0,
           32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
    run_op(MDU_MULTU, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 32'd0, 32'd0,
           32'h00000002, 32'hFFFFFFFA, "multu");
    // Re-run MULTU snooping: old values are the previous MULTU result.
    run_op(MDU_MULTU, 32'h00010000, 32'h00010001, 5, 1'b1, 32'h00000002, 32'hFFFFFFFA,
           32'h00000001, 32'h00010000, "multu2");
    run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 32'd0, 32'd0,
           32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    run_op(MDU_DIVU, 32'd7, 32'd2, 10, 1'b0, 32'd0, 32'd0,
           32'd1, 32'd3, "divu");

    drive(1'b1, MDU_MTHI, 32'h11, 32'd0);
    cyc();
    drive(1'b1, MDU_MTLO, 32'h22, 32'd0);
    cyc();
    run_op(MDU_DIV, 32'd5, 32'd0, 10, 1'b0, 32'd0, 32'd0,
           32'h11, 32'h22, "div0");
    run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'd0, 32'd0,
           32'd0, 32'h80000000, "divovf");

    drive(1'b1, MDU_MTHI, 32'h1234, 32'd0);
    cyc();
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    push(K_HILO, 32'h1234, "mthi readback");
    cyc();
    run_op(MDU_DIVU, 32'd9, 32'd0, 10, 1'b1, 32'h1234, 32'h80000000,
           32'h1234, 32'h80000000, "mtlo-busy");

`ifndef MDU_MADD_EN
    drive(1'b1, MDU_MADD, 32'd2, 32'd3);
    push(K_START, 32'd0, "madd disabled");
    cyc();
    rd(32'h1234, 32'h80000000, "madd nochange");
`endif

    // Reset during the 4th busy cycle of DIV 100/7 (would give HI=2, LO=14).
    drive(1'b1, MDU_DIV, 32'd100, 32'd7);
    push(K_START, 32'd1, "rst div start");
    cyc();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, MDU_NONE, 32'd0, 32'd0);
      if (i == 4) reset = 1'b0;
      push(K_BUSY, 32'd1, $sformatf("rst div busy c%0d", i));
      cyc();
    end
    reset = 1'b1;
    drive(1'b1, MDU_MFHI, 32'd0, 32'd0);
    push(K_BUSY, 32'd0, "rst busy cleared");
    push(K_HILO, 32'd0, "rst HI cleared");
    cyc();
    for (int i = 6; i <= 11; i++) begin
      drive(1'b0, MDU_MULT, 32'd3, 32'd4);
      push(K_START, 32'd0, $sformatf("rst novalid start c%0d", i));
      push(K_BUSY, 32'd0, $sformatf("rst idle c%0d", i));
      cyc();
    end
    rd(32'd0, 32'd0, "rst no commit");

    cyc();
    cyc();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit.
- Owns the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency.
- Serves MTHI/MTLO writes and MFHI/MFLO reads.
- Its read output feeds the E/M pipeline register's HILO input; its start/busy outputs feed the hazard unit, which stalls dependent MDU instructions.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-class ops when enabled); must be ≥1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 clears state at the clock edge).
- valid  in  1  E-stage instruction is real (not flushed or bubbled) and E is not stalled.
- mdu_op  in  4  MDU operation code; `MDU_NONE when the instruction is not an MDU op.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- start  out  1  combinational: valid && op is MULT/MULTU/DIV/DIVU(/MADD-class) && !busy.
- busy  out  1  registered; high while an operation is in flight.
- HILO_out  out  32  combinational: HI for MFHI, LO for MFLO, otherwise 0.

Behaviour:
- State machine has two states:
  - IDLE → BUSY on start. Latch the result into temp_hi/temp_lo from A/B at that edge, and load the counter with the op's cycle count.
  - BUSY: decrement the counter each edge. On the edge where the counter reaches 0, write temp_hi/temp_lo into HI/LO, clear busy, and return to IDLE.
- Timing:
  - busy is high for exactly N cycles following the start edge, where N is the op's cycle count.
  - HI/LO change on the same edge busy falls, so an MFHI in the first cycle with busy==0 sees the new value.
- Arithmetic:
  - MULT: signed 32×32 → 64; HI = result[63:32], LO = result[31:0].
  - MULTU: same split, unsigned.
  - DIV: signed, quotient truncated toward zero → LO; remainder takes the sign of the dividend → HI.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - DIVU: unsigned.
  - Divide by zero (signed or unsigned): still busy for DIV_CYCLES, but HI/LO are left unchanged at completion.
- MTHI/MTLO:
  - Take effect at the edge when valid && !busy: HI (or LO) ← A.
  - Ignored while busy. The hazard unit must not issue them then; the block does not buffer them.
- start while busy is impossible by construction (start is gated by !busy). An MDU op presented during busy has no effect.
- valid==0: no state change regardless of mdu_op.
- HILO_out always reflects the committed HI/LO, never temp values.
- Reset (reset==0 at an edge):
  - HI = LO = 0, temp regs = 0, counter = 0, busy = 0, state = IDLE.
  - Reset mid-operation aborts the operation; no later commit occurs.
- Reset-time output values: start and HILO_out are combinational and follow the rules above given the inputs.

Optional Feature:
- MDU_MADD_EN:
  - When defined, adds MADD, MADDU, MSUB and MSUBU.
  - {HI,LO} ← {HI,LO} ± product, signed or unsigned per op, computed mod 2^64.
  - Captured from the current HI/LO at the start edge; latency MULT_CYCLES.
- When not defined, those op codes decode as `MDU_NONE: no start and no state change.

Decomposition:
- const.v holds:
  - `MDU_NONE, `MDU_MULT, `MDU_MULTU, `MDU_DIV, `MDU_DIVU, `MDU_MFHI, `MDU_MFLO, `MDU_MTHI, `MDU_MTLO, and the MADD-class codes (MADD, MADDU, MSUB, MSUBU).
  - `MDU_IDLE/`MDU_BUSY state encodings.
- No sub-module. The counter and the result-compute logic are small enough to stay inline in e_mdu.

Test Plan:
- MULT with A=0xFFFFFFFE, B=3, valid pulse:
  - start=1 in that cycle; busy high for exactly 5 cycles.
  - Then MFHI → 0xFFFFFFFF and MFLO → 0xFFFFFFFA.
- MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA. MFLO issued during busy still returns the old LO.
- DIV with A=0xFFFFFFF9 (−7), B=2:
  - After 10 busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
- DIV with B=0 after HI=0x11, LO=0x22:
  - busy held 10 cycles, then HI=0x11 and LO=0x22 unchanged.
  - Also DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0x1234 with valid → MFHI next cycle returns 0x1234. An MTLO 0x5678 presented while busy is ignored and LO is unchanged.
- Start DIV, drive reset=0 on the 4th busy cycle:
  - Next cycle busy=0 and HI=LO=0.
  - No commit at the original completion time.
  - With valid=0 and mdu_op=MULT, start stays 0.
